// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: shares one iteration-count RAM (1 write port, 1 read port,
// RD_LATENCY-cycle read latency) between a write client, two read clients and an internal
// clear sequencer that fills the whole RAM with CLEAR_VALUE.
//
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   clear_start / clear_busy   start pulse / busy flag of the full-RAM clear sweep
//   w_valid/w_ready/w_addr/w_data        write client (combinational pass-through in idle)
//   rN_valid/rN_ready/rN_addr            read client N request (N = 0 scanout, 1 host)
//   rN_rsp_valid/rN_rsp_data             read client N response, RD_LATENCY after grant
//   ram_wr_en/ram_wr_addr/ram_wr_data    RAM write port
//   ram_rd_en/ram_rd_addr/ram_rd_data    RAM read port
module ram_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter bit PRIO0 = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    output logic                  r0_rsp_valid,
    output logic [DATA_WIDTH-1:0] r0_rsp_data,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_rsp_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                   rr_q, rr_d;          // 1: r1 wins the next contention
    logic [RD_LATENCY-1:0]  tag_valid_q;
    logic [RD_LATENCY-1:0]  tag_client_q;        // 0 = r0, 1 = r1
    logic [DATA_WIDTH-1:0]  rsp0_data_q, rsp1_data_q;
    logic                   grant0, grant1;

    // State register and all other sequential state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            clr_cnt_q    <= '0;
            rr_q         <= 1'b0;
            tag_valid_q  <= '0;
            tag_client_q <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            rr_q            <= rr_d;
            tag_valid_q[0]  <= grant0 | grant1;
            tag_client_q[0] <= grant1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid_q[i]  <= tag_valid_q[i-1];
                tag_client_q[i] <= tag_client_q[i-1];
            end
            if (r0_rsp_valid) rsp0_data_q <= ram_rd_data;
            if (r1_rsp_valid) rsp1_data_q <= ram_rd_data;
        end
    end

    // Next-state logic: sweep runs exactly DEPTH cycles, ends after writing DEPTH-1.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_d      = rr_q;
        unique case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant0) rr_d = 1'b1;
        if (grant1) rr_d = 1'b0;
    end

    // Outputs: ready and RAM strobes are combinational and forced low during reset.
    always_comb begin
        clear_busy  = (state_q == StClear);
        w_ready     = 1'b0;
        grant0      = 1'b0;
        grant1      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    w_ready     = 1'b1;
                    ram_wr_en   = w_valid;
                    ram_wr_addr = w_addr;
                    ram_wr_data = w_data;
                    if (PRIO0) begin
                        grant0 = r0_valid;
                        grant1 = r1_valid & ~r0_valid;
                    end else if (r0_valid && r1_valid) begin
                        grant0 = ~rr_q;
                        grant1 = rr_q;
                    end else begin
                        grant0 = r0_valid;
                        grant1 = r1_valid;
                    end
                end
                StClear: begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = clr_cnt_q[ADDR_WIDTH-1:0];
                    ram_wr_data = CLEAR_VALUE;
                end
                default: ;
            endcase
        end
        r0_ready = grant0;
        r1_ready = grant1;
        if (grant0 || grant1) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = grant1 ? r1_addr : r0_addr;
        end
        // Oldest tag meets the RAM data; held registers cover the idle cycles.
        r0_rsp_valid = ~reset & tag_valid_q[RD_LATENCY-1] & ~tag_client_q[RD_LATENCY-1];
        r1_rsp_valid = ~reset & tag_valid_q[RD_LATENCY-1] &  tag_client_q[RD_LATENCY-1];
        r0_rsp_data  = r0_rsp_valid ? ram_rd_data : rsp0_data_q;
        r1_rsp_data  = r1_rsp_valid ? ram_rd_data : rsp1_data_q;
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed testbench for ram_access_ctrl: one round-robin instance backed by a 2-cycle
// write-first RAM model, plus a strict-priority instance sharing the same inputs.
module tb_ram_access_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear_start = 1'b0;
    logic       w_valid = 1'b0;
    logic [9:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic       r0_valid = 1'b0;
    logic [9:0] r0_addr = '0;
    logic       r1_valid = 1'b0;
    logic [9:0] r1_addr = '0;

    logic       clear_busy, w_ready, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
    logic [7:0] r0_rsp_data, r1_rsp_data, ram_wr_data, ram_rd_data;
    logic       ram_wr_en, ram_rd_en;
    logic [9:0] ram_wr_addr, ram_rd_addr;

    logic       p_clear_busy, p_w_ready, p_r0_ready, p_r1_ready, p_r0_rsp_valid, p_r1_rsp_valid;
    logic [7:0] p_r0_rsp_data, p_r1_rsp_data, p_ram_wr_data;
    logic [7:0] p_ram_rd_data = 8'h00;
    logic       p_ram_wr_en, p_ram_rd_en;
    logic [9:0] p_ram_wr_addr, p_ram_rd_addr;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    ram_access_ctrl #(.PRIO0(1'b0)) dut (
        .clock(clock), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    ram_access_ctrl #(.PRIO0(1'b1)) dut_p (
        .clock(clock), .reset(reset), .clear_start(clear_start), .clear_busy(p_clear_busy),
        .w_valid(w_valid), .w_ready(p_w_ready), .w_addr(w_addr), .w_data(w_data),
        .r0_valid(r0_valid), .r0_ready(p_r0_ready), .r0_addr(r0_addr),
        .r0_rsp_valid(p_r0_rsp_valid), .r0_rsp_data(p_r0_rsp_data),
        .r1_valid(r1_valid), .r1_ready(p_r1_ready), .r1_addr(r1_addr),
        .r1_rsp_valid(p_r1_rsp_valid), .r1_rsp_data(p_r1_rsp_data),
        .ram_wr_en(p_ram_wr_en), .ram_wr_addr(p_ram_wr_addr), .ram_wr_data(p_ram_wr_data),
        .ram_rd_en(p_ram_rd_en), .ram_rd_addr(p_ram_rd_addr), .ram_rd_data(p_ram_rd_data)
    );

    // Write-first RAM with a data register and an output register: 2-cycle read latency.
    logic [7:0] mem [1024];
    logic [7:0] rd_stage;
    always @(posedge clock) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en)
            rd_stage <= (ram_wr_en && ram_wr_addr == ram_rd_addr) ? ram_wr_data : mem[ram_rd_addr];
        ram_rd_data <= rd_stage;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear_start = 1'b0; w_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        r0_valid = 1'b1; r1_valid = 1'b1; w_valid = 1'b1;
        #1;
        tests++; if (r0_ready !== 1'b0) begin fails++; $display("FAIL rst_r0_ready got %b exp 0", r0_ready); end
        tests++; if (r1_ready !== 1'b0) begin fails++; $display("FAIL rst_r1_ready got %b exp 0", r1_ready); end
        tests++; if (w_ready !== 1'b0) begin fails++; $display("FAIL rst_w_ready got %b exp 0", w_ready); end
        tests++; if ({ram_wr_en, ram_rd_en} !== 2'b00) begin fails++; $display("FAIL rst_ram_en got %b exp 00", {ram_wr_en, ram_rd_en}); end
        tests++; if (clear_busy !== 1'b0) begin fails++; $display("FAIL rst_clear_busy got %b exp 0", clear_busy); end
        tests++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin fails++; $display("FAIL rst_rsp_valid got %b exp 00", {r0_rsp_valid, r1_rsp_valid}); end
        tests++; if ({r0_rsp_data, r1_rsp_data} !== 16'h0000) begin fails++; $display("FAIL rst_rsp_data got %h exp 0000", {r0_rsp_data, r1_rsp_data}); end
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        w_valid = 1'b1; w_addr = 10'd5; w_data = 8'hFD;
        #1;
        tests++; if ({w_ready, ram_wr_en} !== 2'b11) begin fails++; $display("FAIL wr_strobe got %b exp 11", {w_ready, ram_wr_en}); end
        tests++; if ({ram_wr_addr, ram_wr_data} !== {10'd5, 8'hFD}) begin fails++; $display("FAIL wr_pass got %h/%h exp 005/fd", ram_wr_addr, ram_wr_data); end
        tick();
        w_valid = 1'b0; r0_valid = 1'b1; r0_addr = 10'd5;
        #1;
        tests++; if ({r0_ready, r1_ready, ram_rd_en} !== 3'b101) begin fails++; $display("FAIL rd_grant got %b exp 101", {r0_ready, r1_ready, ram_rd_en}); end
        tests++; if (ram_rd_addr !== 10'd5) begin fails++; $display("FAIL rd_addr got %0d exp 5", ram_rd_addr); end
        tick();
        r0_valid = 1'b0;
        #1;
        tests++; if (r0_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_early got %b exp 0", r0_rsp_valid); end
        tick();
        tests++; if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_data} !== {2'b10, 8'hFD}) begin fails++; $display("FAIL rd_rsp got %b%b/%h exp 10/fd", r0_rsp_valid, r1_rsp_valid, r0_rsp_data); end
        tick();
        tests++; if ({r0_rsp_valid, r0_rsp_data} !== {1'b0, 8'hFD}) begin fails++; $display("FAIL rd_hold got %b/%h exp 0/fd", r0_rsp_valid, r0_rsp_data); end
    endtask

    task automatic test_same_cycle();
        w_valid = 1'b1; w_addr = 10'd7; w_data = 8'h12;
        r1_valid = 1'b1; r1_addr = 10'd7;
        #1;
        tests++; if ({r0_ready, r1_ready, ram_rd_en, ram_wr_en} !== 4'b0111) begin fails++; $display("FAIL same_grant got %b exp 0111", {r0_ready, r1_ready, ram_rd_en, ram_wr_en}); end
        tick();
        idle_inputs();
        tick();
        tests++; if ({r0_rsp_valid, r1_rsp_valid, r1_rsp_data} !== {2'b01, 8'h12}) begin fails++; $display("FAIL same_rsp got %b%b/%h exp 01/12", r0_rsp_valid, r1_rsp_valid, r1_rsp_data); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rsp;
        w_valid = 1'b1; w_addr = 10'd10; w_data = 8'h11;
        tick();
        w_addr = 10'd20; w_data = 8'h22;
        tick();
        w_valid = 1'b0; r0_addr = 10'd10; r1_addr = 10'd20;
        for (int i = 0; i < 8; i++) begin
            r0_valid = (i < 6); r1_valid = (i < 6);
            #1;
            if (i < 6) begin
                tests++; if ({r0_ready, r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rr_grant[%0d] got %b%b exp %s", i, r0_ready, r1_ready, (i % 2 == 0) ? "10" : "01"); end
                tests++; if ({p_r0_ready, p_r1_ready} !== 2'b10) begin fails++; $display("FAIL prio_grant[%0d] got %b%b exp 10", i, p_r0_ready, p_r1_ready); end
            end
            if (i >= 2) begin
                exp_rsp = (i % 2 == 0) ? 2'b10 : 2'b01;
                tests++; if ({r0_rsp_valid, r1_rsp_valid} !== exp_rsp) begin fails++; $display("FAIL rr_rsp[%0d] got %b%b exp %b", i, r0_rsp_valid, r1_rsp_valid, exp_rsp); end
                tests++; if ((exp_rsp[1] ? r0_rsp_data : r1_rsp_data) !== (exp_rsp[1] ? 8'h11 : 8'h22)) begin fails++; $display("FAIL rr_data[%0d] got %h/%h", i, r0_rsp_data, r1_rsp_data); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        logic [15:0] exp_vec;
        r1_valid = 1'b1; r1_addr = 10'd20;
        #1;
        tests++; if (r1_ready !== 1'b1) begin fails++; $display("FAIL clr_pre_grant got %b exp 1", r1_ready); end
        tick();
        r1_valid = 1'b0; clear_start = 1'b1;
        #1;
        tests++; if (clear_busy !== 1'b0) begin fails++; $display("FAIL clr_start_busy got %b exp 0", clear_busy); end
        tick();
        r0_valid = 1'b1; r1_valid = 1'b1; r0_addr = 10'd1; r1_addr = 10'd2;
        w_valid = 1'b1; w_addr = 10'd3; w_data = 8'h55;
        for (int c = 0; c < 1024; c++) begin
            clear_start = (c == 100);
            #1;
            exp_vec = {1'b1, 1'b1, 10'(c), 4'b0000};
            tests++; if ({clear_busy, ram_wr_en, ram_wr_addr, w_ready, r0_ready, r1_ready, ram_rd_en} !== exp_vec || ram_wr_data !== 8'h00) begin
                fails++; $display("FAIL clr_cycle[%0d] got %b%b %0d %h %b%b%b%b exp 11 %0d 00 0000", c, clear_busy, ram_wr_en, ram_wr_addr, ram_wr_data, w_ready, r0_ready, r1_ready, ram_rd_en, c);
            end
            if (c == 0) begin
                tests++; if ({r1_rsp_valid, r1_rsp_data} !== {1'b1, 8'h22}) begin fails++; $display("FAIL clr_inflight got %b/%h exp 1/22", r1_rsp_valid, r1_rsp_data); end
            end
            tick();
        end
        idle_inputs();
        r0_valid = 1'b1; r0_addr = 10'd1023;
        #1;
        tests++; if ({clear_busy, ram_wr_en, w_ready, r0_ready} !== 4'b0011) begin fails++; $display("FAIL clr_end got %b exp 0011", {clear_busy, ram_wr_en, w_ready, r0_ready}); end
        tick();
        r0_valid = 1'b0; r1_valid = 1'b1; r1_addr = 10'd5;
        tick();
        r1_valid = 1'b0;
        #1;
        tests++; if ({r0_rsp_valid, r0_rsp_data} !== {1'b1, 8'h00}) begin fails++; $display("FAIL clr_rd1023 got %b/%h exp 1/00", r0_rsp_valid, r0_rsp_data); end
        tick();
        tests++; if ({r1_rsp_valid, r1_rsp_data} !== {1'b1, 8'h00}) begin fails++; $display("FAIL clr_rd5 got %b/%h exp 1/00", r1_rsp_valid, r1_rsp_data); end
        tick();
    endtask

    task automatic test_reset_inflight();
        w_valid = 1'b1; w_addr = 10'd9; w_data = 8'h7E;
        tick();
        w_valid = 1'b0; r0_valid = 1'b1; r0_addr = 10'd9;
        #1;
        tests++; if (r0_ready !== 1'b1) begin fails++; $display("FAIL rif_grant got %b exp 1", r0_ready); end
        tick();
        r0_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests++; if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_data} !== {2'b00, 8'h00}) begin fails++; $display("FAIL rif_dropped got %b%b/%h exp 00/00", r0_rsp_valid, r1_rsp_valid, r0_rsp_data); end
        tick();
        tests++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin fails++; $display("FAIL rif_late got %b%b exp 00", r0_rsp_valid, r1_rsp_valid); end
    endtask

    task automatic test_clear_abort();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 500; c++) tick();
        #1;
        tests++; if ({clear_busy, ram_wr_addr} !== {1'b1, 10'd500}) begin fails++; $display("FAIL abort_cnt got %b/%0d exp 1/500", clear_busy, ram_wr_addr); end
        reset = 1'b1;
        #1;
        tests++; if ({ram_wr_en, w_ready} !== 2'b00) begin fails++; $display("FAIL abort_rst_strobe got %b exp 00", {ram_wr_en, w_ready}); end
        tick();
        reset = 1'b0;
        #1;
        tests++; if ({clear_busy, w_ready, ram_wr_en, r0_rsp_valid, r1_rsp_valid} !== 5'b01000) begin fails++; $display("FAIL abort_idle got %b exp 01000", {clear_busy, w_ready, ram_wr_en, r0_rsp_valid, r1_rsp_valid}); end
        tick();
        tests++; if (clear_busy !== 1'b0) begin fails++; $display("FAIL abort_stay got %b exp 0", clear_busy); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_round_robin();
        test_clear();
        test_reset_inflight();
        test_clear_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
